// File: rtl/prio_req_if.sv
// Request/grant bundle between raw event lines, the priority arbiter and its consumer.
// master drives requests, mask and ack; slave is the arbiter side.
interface prio_req_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ack;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] pending;
  logic         dropped;

  modport master (
    output req, mask, ack,
    input  valid, idx, pending, dropped
  );

  modport slave (
    input  req, mask, ack,
    output valid, idx, pending, dropped
  );
endinterface

// File: rtl/prio_req_arbiter.sv
// Registered N-line priority arbiter: sticky pending capture, enable mask, and a
// grant held until acknowledged. Fixed (highest index) or round-robin selection.
module prio_req_arbiter #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 0
) (
  input  logic      clk,
  input  logic      rst,
  prio_req_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [N-1:0] pend_q;
  logic         vld_q;
  logic [W-1:0] idx_q;
  logic         drop_q;
  logic [W-1:0] top_q;

  logic [N-1:0] clr;
  logic [N-1:0] elig;
  logic [W-1:0] sel;

  // Highest set index in e; the legacy encoder ordering.
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] e);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (e[i]) s = W'(i);
    end
    return s;
  endfunction

  // First set bit scanning down from top, wrapping to N-1 after 0: the highest set
  // bit at or below top, else the highest set bit overall.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] e, input logic [W-1:0] top);
    logic [W-1:0] s_lo;
    logic [W-1:0] s_all;
    logic         any_lo;
    s_lo   = '0;
    s_all  = '0;
    any_lo = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (e[i]) begin
        s_all = W'(i);
        if (W'(i) <= top) begin
          s_lo   = W'(i);
          any_lo = 1'b1;
        end
      end
    end
    return any_lo ? s_lo : s_all;
  endfunction

  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.ack && vld_q && (idx_q == W'(i))) clr[i] = 1'b1;
    end
  end

  assign elig = pend_q & bus.mask;
  assign sel  = (RR != 0) ? sel_rr(elig, top_q) : sel_fixed(elig);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      drop_q <= 1'b0;
      top_q  <= W'(N - 1);
    end else begin
      // A req landing on a bit being cleared this cycle re-arms it.
      pend_q <= (pend_q & ~clr) | bus.req;
      drop_q <= |(bus.req & pend_q & ~clr);
      case (state)
        IDLE: begin
          if (|elig) begin
            idx_q <= sel;
            vld_q <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            vld_q <= 1'b0;
            state <= IDLE;
            if (RR != 0) top_q <= (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
          end
        end
        default: begin
          vld_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.valid   = vld_q;
  assign bus.idx     = idx_q;
  assign bus.pending = pend_q;
  assign bus.dropped = drop_q;

endmodule
